// File: rtl/fact_ctrl.sv
// Memory-mapped iterative factorial engine: software loads N, writes GO,
// and polls STATUS (or takes done_irq) before reading RESULT.
module fact_ctrl #(
  parameter int unsigned MAX_N = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WE,
  input  logic [1:0]  A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        done_irq
);

  localparam int unsigned NW = 4;
  localparam int unsigned DW = 32;
  localparam logic [NW-1:0] MAX_N_V = NW'(MAX_N);

  localparam logic [1:0] REG_N      = 2'd0;
  localparam logic [1:0] REG_GO     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic [NW-1:0]   n_q, n_nxt;
  logic [NW-1:0]   cnt_q, cnt_nxt;
  logic [DW-1:0]   prod_q, prod_nxt;
  logic [DW-1:0]   result_q, result_nxt;
  logic            done_q, done_nxt;
  logic            err_q, err_nxt;
  logic [DW-1:0]   mul_lo;
  logic            wr_n, wr_go, busy;
  logic            unused_wd;

  assign busy      = (state == BUSY);
  assign wr_n      = WE && (A == REG_N);
  assign wr_go     = WE && (A == REG_GO) && WD[0];
  assign unused_wd = ^WD[31:4];

  // 32x4 product; truncation to 32 bits never loses data while N <= MAX_N
  assign mul_lo = prod_q * DW'(cnt_q);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      n_q      <= n_nxt;
      cnt_q    <= cnt_nxt;
      prod_q   <= prod_nxt;
      result_q <= result_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  // Next-state and register updates; bus writes only act in IDLE
  always_comb begin
    state_nxt  = state;
    n_nxt      = n_q;
    cnt_nxt    = cnt_q;
    prod_nxt   = prod_q;
    result_nxt = result_q;
    done_nxt   = done_q;
    err_nxt    = err_q;
    case (state)
      IDLE: begin
        if (wr_n) n_nxt = WD[NW-1:0];
        if (wr_go) begin
          if (n_q <= MAX_N_V) begin
            done_nxt  = 1'b0;
            err_nxt   = 1'b0;
            prod_nxt  = DW'(1);
            cnt_nxt   = n_q;
            state_nxt = BUSY;
          end else begin
            done_nxt   = 1'b1;
            err_nxt    = 1'b1;
            result_nxt = '0;
          end
        end
      end
      BUSY: begin
        if (cnt_q > NW'(1)) begin
          prod_nxt = mul_lo;
          cnt_nxt  = cnt_q - NW'(1);
        end else begin
          result_nxt = prod_q;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end
      end
    endcase
  end

  // Combinational read mux
  always_comb begin
    RD = '0;
    case (A)
      REG_N:      RD = DW'(n_q);
      REG_GO:     RD = DW'(busy);
      REG_STATUS: RD = DW'({busy, err_q, done_q});
      REG_RESULT: RD = result_q;
    endcase
  end

  assign done_irq = done_q;

endmodule

// File: tb/tb_fact_ctrl.sv
// Directed self-checking bench for fact_ctrl using immediate assertions.
module tb_fact_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [1:0]  a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        done_irq;

  int n_cmp  = 0;
  int n_fail = 0;

  fact_ctrl #(.MAX_N(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .WE       (we),
    .A        (a),
    .WD       (wd),
    .RD       (rd),
    .done_irq (done_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write one register on the next rising edge; returns 1 time unit after it
  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1; a = addr; wd = data;
    @(posedge clk);
    #1;
    we = 1'b0; wd = '0;
  endtask

  task automatic rdreg(input logic [1:0] addr, output logic [31:0] data);
    a = addr;
    #1;
    data = rd;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    rdreg(addr, v);
    check(tag, v, exp);
  endtask

  // Count edges until done_irq rises, bounded
  task automatic wait_done(input string tag, input int exp_lat);
    int cyc = 0;
    while (done_irq !== 1'b1 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check(tag, 32'(cyc), 32'(exp_lat));
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; a = 2'd0; wd = '0;
    #12;
    check_reg("rst_n_in_reset", 2'd0, 32'd0);
    check_reg("rst_result_in_reset", 2'd3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reg("rst_n", 2'd0, 32'd0);
    check_reg("rst_go", 2'd1, 32'd0);
    check_reg("rst_status", 2'd2, 32'd0);
    check_reg("rst_result", 2'd3, 32'd0);
    check("rst_irq", 32'(done_irq), 32'd0);

    // 5! = 120
    wr(2'd0, 32'd5);
    check_reg("n5_readback", 2'd0, 32'd5);
    wr(2'd1, 32'd1);
    check_reg("n5_busy", 2'd1, 32'd1);
    check_reg("n5_status_busy", 2'd2, 32'h4);
    wait_done("n5_latency", 5);
    check_reg("n5_status", 2'd2, 32'h1);
    check_reg("n5_result", 2'd3, 32'd120);
    check("n5_irq", 32'(done_irq), 32'd1);

    // 0! = 1 in one cycle
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd1);
    check("n0_irq_cleared", 32'(done_irq), 32'd0);
    wait_done("n0_latency", 1);
    check_reg("n0_result", 2'd3, 32'd1);

    // 12! = 479001600
    wr(2'd0, 32'd12);
    wr(2'd1, 32'd1);
    check_reg("n12_result_held", 2'd3, 32'd1);
    wait_done("n12_latency", 12);
    check_reg("n12_result", 2'd3, 32'h1C8CFC00);
    check_reg("n12_status", 2'd2, 32'h1);

    // GO with bit0 clear does nothing
    wr(2'd1, 32'hFFFF_FFFE);
    check_reg("go0_status", 2'd2, 32'h1);

    // 13 exceeds MAX_N: immediate error, never busy
    wr(2'd0, 32'd13);
    wr(2'd1, 32'd1);
    check_reg("n13_status", 2'd2, 32'h3);
    check_reg("n13_result", 2'd3, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reg("n13_status_later", 2'd2, 32'h3);

    // Writes during BUSY are ignored
    wr(2'd0, 32'd6);
    wr(2'd1, 32'd1);
    check_reg("n6_status_cleared", 2'd2, 32'h4);
    wr(2'd0, 32'd3);
    wr(2'd1, 32'd1);
    check_reg("n6_result_held", 2'd3, 32'd0);
    wait_done("n6_latency_rest", 4);
    check_reg("n6_result", 2'd3, 32'd720);
    check_reg("n6_n_kept", 2'd0, 32'd6);

    // GO on the completion edge is ignored
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd1);
    wr(2'd1, 32'd1);
    check_reg("samedge_status", 2'd2, 32'h1);
    check_reg("samedge_result", 2'd3, 32'd1);

    // Reset mid-run aborts, then a fresh run works
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reg("abort_n", 2'd0, 32'd0);
    check_reg("abort_go", 2'd1, 32'd0);
    check_reg("abort_status", 2'd2, 32'd0);
    check_reg("abort_result", 2'd3, 32'd0);
    check("abort_irq", 32'(done_irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(2'd0, 32'd4);
    wr(2'd1, 32'd1);
    wait_done("n4_latency", 4);
    check_reg("n4_result", 2'd3, 32'd24);
    check_reg("n4_status", 2'd2, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
